// File: rtl/uart_loader_pkg.sv
// Shared constants for the UART program loader: sync byte and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_loader_pkg;

    // First byte of every program frame
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Loader FSM encoding
    localparam logic [2:0] LD_SYNC = 3'd0;
    localparam logic [2:0] LD_LEN0 = 3'd1;
    localparam logic [2:0] LD_LEN1 = 3'd2;
    localparam logic [2:0] LD_DATA = 3'd3;
    localparam logic [2:0] LD_CSUM = 3'd4;
    localparam logic [2:0] LD_DONE = 3'd5;

    // UART receive FSM encoding
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_loader_if.sv
// Instruction-memory write port driven by the loader.
// Latency: n/a (signal bundle only).
// Backpressure: none; imem accepts a write every cycle imem_we is high.
interface uart_loader_if #(
    parameter int ADDR_W = 10
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_loader_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/error pulses.
// Latency: byte_vld pulses the cycle after the stop bit is sampled (mid stop bit).
// Backpressure: none; a byte must be consumed in its byte_vld cycle.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int DIV = 868
) (
    input  logic       CLK100MHZ,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] byte_dat,
    output logic       byte_vld,
    output logic       frame_err
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);

    logic          sync1, sync2;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign byte_dat = shift;

    // Bring the asynchronous line into the clock domain; idle level is high
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
        end
    end

    // Start-bit qualification at half a bit, then sample each bit at its centre
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            st        <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (!sync2) begin
                        st  <= RX_START;
                        cnt <= CNT_HALF;
                    end
                end
                RX_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (sync2) begin
                        st <= RX_IDLE;          // glitch, not a start bit
                    end else begin
                        st      <= RX_DATA;
                        cnt     <= CNT_FULL;
                        bit_idx <= '0;
                    end
                end
                RX_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shift <= {sync2, shift[7:1]};
                        cnt   <= CNT_FULL;
                        if (bit_idx == 3'd7) st <= RX_STOP;
                        else                 bit_idx <= bit_idx + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (sync2) byte_vld  <= 1'b1;
                        else       frame_err <= 1'b1;
                        st <= RX_IDLE;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_loader.sv
// Boot loader: receives a framed image over UART, writes 32-bit words to imem, releases the cpu.
// Latency: imem write one cycle after the 4th byte of a word; cpu_run one cycle after a good checksum.
// Backpressure: none; imem must accept every strobe, the UART cannot be stalled.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_HZ    = 100000000,
    parameter int BAUD      = 115200,
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic            CLK100MHZ,
    input  logic            rst,
    input  logic            uart_rx,
    uart_loader_if.master   imem,
    output logic            cpu_run,
    output logic            busy,
    output logic            load_err
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    logic [7:0]  byte_dat;
    logic        byte_vld;
    logic        frame_err;

    logic [2:0]  st;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] idx;
    logic [1:0]  bidx;
    logic [23:0] word;
    logic [7:0]  csum;
    logic [15:0] n_words;

    uart_rx_byte #(.DIV(DIV)) u_rx (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .byte_dat  (byte_dat),
        .byte_vld  (byte_vld),
        .frame_err (frame_err)
    );

    assign n_words = {byte_dat, len_lo};

    // busy covers every state between the sync byte and the checksum verdict
    always_comb begin
        busy = (st == LD_LEN0) || (st == LD_LEN1) || (st == LD_DATA) || (st == LD_CSUM);
    end

    // Frame parser: header, little-endian word assembly with imem writes, checksum verdict
    always_ff @(posedge CLK100MHZ) begin
        if (rst) begin
            st              <= LD_SYNC;
            imem.imem_we    <= 1'b0;
            imem.imem_addr  <= '0;
            imem.imem_wdata <= '0;
            cpu_run         <= 1'b0;
            load_err        <= 1'b0;
            len_lo          <= '0;
            len             <= '0;
            idx             <= '0;
            bidx            <= '0;
            word            <= '0;
            csum            <= '0;
        end else begin
            imem.imem_we <= 1'b0;
            if (st != LD_DONE && frame_err) begin
                load_err <= 1'b1;
                st       <= LD_SYNC;
            end else if (st != LD_DONE && byte_vld) begin
                case (st)
                    LD_SYNC: begin
                        if (byte_dat == SYNC_BYTE) begin
                            st       <= LD_LEN0;
                            load_err <= 1'b0;
                        end
                    end
                    LD_LEN0: begin
                        len_lo <= byte_dat;
                        st     <= LD_LEN1;
                    end
                    LD_LEN1: begin
                        if (n_words == '0 || {1'b0, n_words} > MAX_N) begin
                            load_err <= 1'b1;
                            st       <= LD_SYNC;
                        end else begin
                            len  <= n_words;
                            idx  <= '0;
                            bidx <= '0;
                            csum <= '0;
                            st   <= LD_DATA;
                        end
                    end
                    LD_DATA: begin
                        word <= {byte_dat, word[23:8]};
                        csum <= csum ^ byte_dat;
                        bidx <= bidx + 1'b1;
                        if (bidx == 2'd3) begin
                            imem.imem_we    <= 1'b1;
                            imem.imem_addr  <= idx[ADDR_W-1:0];
                            imem.imem_wdata <= {byte_dat, word};
                            idx             <= idx + 1'b1;
                            if (idx + 16'd1 == len) st <= LD_CSUM;
                        end
                    end
                    LD_CSUM: begin
                        if (byte_dat == csum) begin
                            cpu_run <= 1'b1;
                            st      <= LD_DONE;
                        end else begin
                            load_err <= 1'b1;
                            st       <= LD_SYNC;
                        end
                    end
                    default: st <= LD_SYNC;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial frames in, imem writes checked against a scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_loader;
    import uart_loader_pkg::*;

    localparam int CLK_HZ    = 1000000;
    localparam int BAUD      = 125000;
    localparam int DIV       = CLK_HZ / BAUD;
    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic CLK100MHZ = 1'b0;
    logic rst       = 1'b1;
    logic uart_rx   = 1'b1;
    logic cpu_run, busy, load_err;

    always #5 CLK100MHZ = ~CLK100MHZ;

    uart_loader_if #(.ADDR_W(ADDR_W)) imem_bus ();

    uart_loader #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .ADDR_W    (ADDR_W),
        .MAX_WORDS (MAX_WORDS)
    ) u_dut (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .imem      (imem_bus),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .load_err  (load_err)
    );

    int n_chk   = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_we    = 0;
    int n_bytes = 0;
    logic prev_we = 1'b0;
    logic [ADDR_W+31:0] sb[$];
    logic [31:0] payload[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK100MHZ);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop_ok;
        tick(DIV);
        uart_rx = 1'b1;
        tick(2 * DIV);
    endtask

    // live=1: loader should accept the frame, so expected writes are queued
    task automatic send_frame(input logic [15:0] n, input bit bad_csum, input bit live);
        logic [7:0] cs;
        logic [31:0] w;
        cs = 8'h00;
        send_byte(SYNC_BYTE, 1'b1);
        if (live) check("busy_after_sync", {31'b0, busy}, 32'd1);
        send_byte(n[7:0], 1'b1);
        send_byte(n[15:8], 1'b1);
        foreach (payload[k]) begin
            w = payload[k];
            if (live) sb.push_back({ADDR_W'(k), w});
            for (int j = 0; j < 4; j++) begin
                cs = cs ^ w[8*j +: 8];
                send_byte(w[8*j +: 8], 1'b1);
            end
        end
        send_byte(bad_csum ? (cs ^ 8'h01) : cs, 1'b1);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    {31'b0, imem_bus.imem_we}, 32'd0);
        check({tag, "_addr"},  32'(imem_bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_bus.imem_wdata, 32'd0);
        check({tag, "_run"},   {31'b0, cpu_run}, 32'd0);
        check({tag, "_busy"},  {31'b0, busy}, 32'd0);
        check({tag, "_err"},   {31'b0, load_err}, 32'd0);
    endtask

    // Write monitor: every strobe must be a single cycle and match the head of the scoreboard
    always @(negedge CLK100MHZ) begin
        logic [ADDR_W+31:0] e;
        if (u_dut.u_rx.byte_vld) n_bytes++;
        if (imem_bus.imem_we) begin
            n_we++;
            check("we_single_cycle", {31'b0, prev_we}, 32'd0);
            check("we_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("we_addr",  32'(imem_bus.imem_addr), 32'(e[ADDR_W+31:32]));
                check("we_wdata", imem_bus.imem_wdata, e[31:0]);
            end
        end
        prev_we = imem_bus.imem_we;
    end

    initial begin
        payload.push_back(32'h00500013);
        payload.push_back(32'h00100093);

        rst = 1'b1;
        tick(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(2);

        // garbage before sync is received but ignored
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        check("garbage_bytes", 32'(n_bytes), 32'd2);
        check("garbage_busy", {31'b0, busy}, 32'd0);
        check("garbage_err", {31'b0, load_err}, 32'd0);

        // short low glitch must not start a byte
        uart_rx = 1'b0;
        tick(2);
        uart_rx = 1'b1;
        tick(3 * DIV);
        check("glitch_no_byte", 32'(n_bytes), 32'd2);

        // stop bit low: no byte, error flagged
        send_byte(8'h55, 1'b0);
        check("frame_err_no_byte", 32'(n_bytes), 32'd2);
        check("frame_err_flag", {31'b0, load_err}, 32'd1);
        check("frame_err_busy", {31'b0, busy}, 32'd0);

        // bad checksum: words written, error, no run
        send_frame(16'd2, 1'b1, 1'b1);
        check("badcs_err", {31'b0, load_err}, 32'd1);
        check("badcs_run", {31'b0, cpu_run}, 32'd0);
        check("badcs_busy", {31'b0, busy}, 32'd0);
        check("badcs_we_count", 32'(n_we), 32'd2);
        check("hold_addr", 32'(imem_bus.imem_addr), 32'd1);
        check("hold_wdata", imem_bus.imem_wdata, 32'h00100093);

        // zero length
        send_byte(SYNC_BYTE, 1'b1);
        check("sync_clears_err", {31'b0, load_err}, 32'd0);
        check("sync_sets_busy", {31'b0, busy}, 32'd1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("len0_err", {31'b0, load_err}, 32'd1);
        check("len0_busy", {31'b0, busy}, 32'd0);

        // one word over the limit
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'(MAX_WORDS + 1), 1'b1);
        send_byte(8'((MAX_WORDS + 1) >> 8), 1'b1);
        check("lenmax_err", {31'b0, load_err}, 32'd1);
        check("lenmax_busy", {31'b0, busy}, 32'd0);
        check("len_no_we", 32'(n_we), 32'd2);

        // reset in the middle of the payload
        send_byte(SYNC_BYTE, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h50, 1'b1);
        check("midrst_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("midrst");
        rst = 1'b0;
        tick(2);

        // clean load
        send_frame(16'd2, 1'b0, 1'b1);
        check("good_run", {31'b0, cpu_run}, 32'd1);
        check("good_busy", {31'b0, busy}, 32'd0);
        check("good_err", {31'b0, load_err}, 32'd0);
        check("good_we_count", 32'(n_we), 32'd4);

        // after DONE everything is ignored
        send_frame(16'd2, 1'b0, 1'b0);
        check("done_run", {31'b0, cpu_run}, 32'd1);
        check("done_busy", {31'b0, busy}, 32'd0);
        check("done_no_we", 32'(n_we), 32'd4);

        tick(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
